// File: rtl/cmp_if.sv
// Bus between the sweep driver (initiator) and a registered magnitude comparator.
// The driver sends operands and mode enable; the comparator returns G/L/E flags.
interface cmp_if #(
   parameter int W = 4
);
   logic [W-1:0] A_out;
   logic [W-1:0] B_out;
   logic         C3_out;
   logic [3:0]   G_in;
   logic [3:0]   L_in;
   logic [3:0]   E_in;

   modport master (
      output A_out, B_out, C3_out,
      input  G_in, L_in, E_in
   );

   modport slave (
      input  A_out, B_out, C3_out,
      output G_in, L_in, E_in
   );
endinterface

// File: rtl/cmp_sweep_driver.sv
// Exhaustive operand sweep for comparator self-test: drives every (A,B) pair,
// checks the returned G/L/E flags and accumulates greater/less/equal/error counts.
module cmp_sweep_driver #(
   parameter int W     = 4,
   parameter int LAT   = 1,
   parameter int CNT_W = 2*W+1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   cmp_if.master            cmp,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] gt_cnt,
   output logic [CNT_W-1:0] lt_cnt,
   output logic [CNT_W-1:0] eq_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic             err
);
   typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CAPTURE, DONE} state_t;

   // Counter only needs to reach LAT-2; WAIT is bypassed entirely when LAT==1.
   localparam int WC_W = (LAT > 2) ? $clog2(LAT-1) : 1;
   localparam logic [WC_W-1:0] WAIT_LAST = WC_W'((LAT > 1) ? (LAT-2) : 0);

   state_t           state_reg, state_next;
   logic [W-1:0]     a_reg, b_reg;
   logic [WC_W-1:0]  wait_cnt_reg;
   logic [CNT_W-1:0] gt_cnt_reg, lt_cnt_reg, eq_cnt_reg, err_cnt_reg;
   logic             err_reg;
   logic             c3;
   logic             last_pair;
   logic [3:0]       exp_flag, oth_flag0, oth_flag1;
   logic             result_ok;

   assign last_pair = (&a_reg) & (&b_reg);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_reg <= IDLE;
      else      state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      busy       = 1'b0;
      done       = 1'b0;
      c3         = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) state_next = DRIVE;
         end
         DRIVE: begin
            busy       = 1'b1;
            c3         = 1'b1;
            state_next = (LAT > 1) ? WAIT : CAPTURE;
         end
         WAIT: begin
            busy = 1'b1;
            c3   = 1'b1;
            if (wait_cnt_reg == WAIT_LAST) state_next = CAPTURE;
         end
         CAPTURE: begin
            busy       = 1'b1;
            c3         = 1'b1;
            state_next = last_pair ? DONE : DRIVE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Select the flag that should be 1 for this pair; the other two must be 0.
   always_comb begin
      if (a_reg > b_reg) begin
         exp_flag  = cmp.G_in;
         oth_flag0 = cmp.L_in;
         oth_flag1 = cmp.E_in;
      end else if (a_reg < b_reg) begin
         exp_flag  = cmp.L_in;
         oth_flag0 = cmp.G_in;
         oth_flag1 = cmp.E_in;
      end else begin
         exp_flag  = cmp.E_in;
         oth_flag0 = cmp.G_in;
         oth_flag1 = cmp.L_in;
      end
      result_ok = (exp_flag == 4'd1) && (oth_flag0 == 4'd0) && (oth_flag1 == 4'd0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_reg        <= '0;
         b_reg        <= '0;
         wait_cnt_reg <= '0;
         gt_cnt_reg   <= '0;
         lt_cnt_reg   <= '0;
         eq_cnt_reg   <= '0;
         err_cnt_reg  <= '0;
         err_reg      <= 1'b0;
      end else begin
         wait_cnt_reg <= (state_reg == WAIT) ? wait_cnt_reg + WC_W'(1) : '0;
         if (state_reg == IDLE && start) begin
            a_reg       <= '0;
            b_reg       <= '0;
            gt_cnt_reg  <= '0;
            lt_cnt_reg  <= '0;
            eq_cnt_reg  <= '0;
            err_cnt_reg <= '0;
            err_reg     <= 1'b0;
         end else if (state_reg == CAPTURE) begin
            if (!result_ok) begin
               err_cnt_reg <= err_cnt_reg + CNT_W'(1);
               err_reg     <= 1'b1;
            end else if (a_reg > b_reg) begin
               gt_cnt_reg <= gt_cnt_reg + CNT_W'(1);
            end else if (a_reg < b_reg) begin
               lt_cnt_reg <= lt_cnt_reg + CNT_W'(1);
            end else begin
               eq_cnt_reg <= eq_cnt_reg + CNT_W'(1);
            end
            // Final pair keeps its operands; the next start rewinds them.
            if (!last_pair) {a_reg, b_reg} <= {a_reg, b_reg} + (2*W)'(1);
         end
      end
   end

   assign cmp.A_out  = a_reg;
   assign cmp.B_out  = b_reg;
   assign cmp.C3_out = c3;
   assign gt_cnt     = gt_cnt_reg;
   assign lt_cnt     = lt_cnt_reg;
   assign eq_cnt     = eq_cnt_reg;
   assign err_cnt    = err_cnt_reg;
   assign err        = err_reg;
endmodule

// File: tb/tb_cmp_sweep_driver.sv
// Directed bench: two drivers (LAT=1 and LAT=2) against behavioural comparator models,
// with fault-injecting modes on the LAT=1 model.
module tb_cmp_sweep_driver;
   localparam int W     = 4;
   localparam int CNT_W = 2*W+1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start1 = 1'b0;
   logic start2 = 1'b0;
   int   mode = 0;   // 0 ideal, 1 G stuck at 0, 2 G and E both set at (5,5)

   always #5 clk = ~clk;

   cmp_if #(.W(W)) cmp1 ();
   cmp_if #(.W(W)) cmp2 ();

   logic             busy1, done1, err1, busy2, done2, err2;
   logic [CNT_W-1:0] gt1, lt1, eq1, ec1, gt2, lt2, eq2, ec2;

   cmp_sweep_driver #(.W(W), .LAT(1), .CNT_W(CNT_W)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .cmp(cmp1.master),
      .busy(busy1), .done(done1), .gt_cnt(gt1), .lt_cnt(lt1),
      .eq_cnt(eq1), .err_cnt(ec1), .err(err1)
   );

   cmp_sweep_driver #(.W(W), .LAT(2), .CNT_W(CNT_W)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .cmp(cmp2.master),
      .busy(busy2), .done(done2), .gt_cnt(gt2), .lt_cnt(lt2),
      .eq_cnt(eq2), .err_cnt(ec2), .err(err2)
   );

   // Single-stage comparator with selectable faults.
   always @(posedge clk) begin
      if (cmp1.C3_out) begin
         cmp1.G_in <= (cmp1.A_out > cmp1.B_out) ? 4'd1 : 4'd0;
         cmp1.L_in <= (cmp1.A_out < cmp1.B_out) ? 4'd1 : 4'd0;
         cmp1.E_in <= (cmp1.A_out == cmp1.B_out) ? 4'd1 : 4'd0;
         if (mode == 1) cmp1.G_in <= 4'd0;
         if (mode == 2 && cmp1.A_out == 4'd5 && cmp1.B_out == 4'd5) cmp1.G_in <= 4'd1;
      end
   end

   // Two-stage ideal comparator.
   logic [3:0] g_s1, l_s1, e_s1;
   always @(posedge clk) begin
      g_s1 <= (cmp2.A_out > cmp2.B_out) ? 4'd1 : 4'd0;
      l_s1 <= (cmp2.A_out < cmp2.B_out) ? 4'd1 : 4'd0;
      e_s1 <= (cmp2.A_out == cmp2.B_out) ? 4'd1 : 4'd0;
      cmp2.G_in <= g_s1;
      cmp2.L_in <= l_s1;
      cmp2.E_in <= e_s1;
   end

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_start(input int sel, input logic v);
      if (sel == 0) start1 = v;
      else          start2 = v;
   endtask

   // Pulse start, then count busy cycles and done pulses until 3 cycles after done.
   task automatic sweep(input int sel, input int repulse_at, input bit start_on_done,
                        output int bcyc, output int dpulse);
      int   done_at;
      logic b, d;
      bcyc    = 0;
      dpulse  = 0;
      done_at = -1;
      @(negedge clk); set_start(sel, 1'b1);
      @(negedge clk); set_start(sel, 1'b0);
      for (int i = 0; i < 3000; i++) begin
         b = (sel == 0) ? busy1 : busy2;
         d = (sel == 0) ? done1 : done2;
         if (b) bcyc++;
         if (d) begin
            dpulse++;
            done_at = i;
         end
         set_start(sel, (i == repulse_at) || (d && start_on_done));
         if (done_at >= 0 && i >= done_at + 3) break;
         @(negedge clk);
      end
      set_start(sel, 1'b0);
   endtask

   task automatic chk_counts1(input string t, input int g, input int l, input int e,
                              input int ec, input logic er);
      chk({t, "_gt"}, 32'(gt1), 32'(g));
      chk({t, "_lt"}, 32'(lt1), 32'(l));
      chk({t, "_eq"}, 32'(eq1), 32'(e));
      chk({t, "_errcnt"}, 32'(ec1), 32'(ec));
      chk({t, "_err"}, 32'(err1), 32'(er));
   endtask

   int bc, dp;

   initial begin
      // Reset state
      #1;
      chk("rst_busy", 32'(busy1), 0);
      chk("rst_done", 32'(done1), 0);
      chk("rst_c3", 32'(cmp1.C3_out), 0);
      chk("rst_a", 32'(cmp1.A_out), 0);
      chk("rst_b", 32'(cmp1.B_out), 0);
      chk_counts1("rst", 0, 0, 0, 0, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("idle_c3", 32'(cmp1.C3_out), 0);

      // 1: ideal comparator
      mode = 0;
      sweep(0, -1, 1'b0, bc, dp);
      chk("t1_busy_cycles", 32'(bc), 512);
      chk("t1_done_pulses", 32'(dp), 1);
      chk_counts1("t1", 120, 120, 16, 0, 1'b0);
      $display("t1 ideal: busy=%0d done=%0d gt=%0d lt=%0d eq=%0d errcnt=%0d", bc, dp, gt1, lt1, eq1, ec1);

      // 2: G stuck at 0
      mode = 1;
      sweep(0, -1, 1'b0, bc, dp);
      chk_counts1("t2", 0, 120, 16, 120, 1'b1);
      $display("t2 g_stuck0: gt=%0d lt=%0d eq=%0d errcnt=%0d err=%0d", gt1, lt1, eq1, ec1, err1);

      // 3: non-one-hot result at (5,5)
      mode = 2;
      sweep(0, -1, 1'b0, bc, dp);
      chk_counts1("t3", 120, 120, 15, 1, 1'b1);
      $display("t3 dual_flag: gt=%0d lt=%0d eq=%0d errcnt=%0d err=%0d", gt1, lt1, eq1, ec1, err1);

      // 4: start re-pulsed at pair 10 and on the done cycle, both ignored
      mode = 0;
      sweep(0, 20, 1'b1, bc, dp);
      chk("t4_busy_cycles", 32'(bc), 512);
      chk("t4_done_pulses", 32'(dp), 1);
      chk("t4_start_on_done_ignored", 32'(busy1), 0);
      chk_counts1("t4a", 120, 120, 16, 0, 1'b0);
      sweep(0, -1, 1'b0, bc, dp);
      chk("t4b_done_pulses", 32'(dp), 1);
      chk_counts1("t4b", 120, 120, 16, 0, 1'b0);
      $display("t4 repulse: busy=%0d done=%0d gt=%0d lt=%0d eq=%0d errcnt=%0d", bc, dp, gt1, lt1, eq1, ec1);

      // 5: reset during CAPTURE of pair 37 (a=2,b=5), busy cycle 75
      @(negedge clk); start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      repeat (75) @(negedge clk);
      chk("t5_pair_a", 32'(cmp1.A_out), 2);
      chk("t5_pair_b", 32'(cmp1.B_out), 5);
      chk("t5_in_sweep", 32'(busy1), 1);
      rst = 1'b0;
      #1;
      chk("t5_busy", 32'(busy1), 0);
      chk("t5_c3", 32'(cmp1.C3_out), 0);
      chk("t5_a", 32'(cmp1.A_out), 0);
      chk("t5_b", 32'(cmp1.B_out), 0);
      chk("t5_done", 32'(done1), 0);
      chk_counts1("t5rst", 0, 0, 0, 0, 1'b0);
      dp = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done1) dp++;
         if (i == 3) rst = 1'b1;
      end
      chk("t5_no_done", 32'(dp), 0);
      chk("t5_idle_after", 32'(busy1), 0);
      sweep(0, -1, 1'b0, bc, dp);
      chk("t5_busy_cycles", 32'(bc), 512);
      chk_counts1("t5", 120, 120, 16, 0, 1'b0);
      $display("t5 mid_reset: busy=%0d gt=%0d lt=%0d eq=%0d errcnt=%0d", bc, gt1, lt1, eq1, ec1);

      // 6: LAT=2 driver with two-stage comparator
      sweep(1, -1, 1'b0, bc, dp);
      chk("t6_busy_cycles", 32'(bc), 768);
      chk("t6_done_pulses", 32'(dp), 1);
      chk("t6_gt", 32'(gt2), 120);
      chk("t6_lt", 32'(lt2), 120);
      chk("t6_eq", 32'(eq2), 16);
      chk("t6_errcnt", 32'(ec2), 0);
      chk("t6_err", 32'(err2), 0);
      $display("t6 lat2: busy=%0d done=%0d gt=%0d lt=%0d eq=%0d errcnt=%0d", bc, dp, gt2, lt2, eq2, ec2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
